// File: rtl/pll_lock_sequencer.sv
// Reset/lock sequencer for the hashing-clock PLL: pulses the PLL reset, filters lock, settles, then monitors.
// Define PLL_SEQ_AUTO_RETRY_EN to retry forever on timeout/lock loss; otherwise those events park in FAULT.
`timescale 1ns/1ps
module pll_lock_sequencer #(
  parameter int AREF_CYCLES   = 10,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int LOCK_FILTER   = 16,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_areset,
  output logic       core_reset,
  output logic       clk_ok,
  output logic       fault,
  output logic [7:0] retry_count
);

  localparam int MAX_AT = (AREF_CYCLES > LOCK_TIMEOUT) ? AREF_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_FS = (LOCK_FILTER > SETTLE_CYCLES) ? LOCK_FILTER : SETTLE_CYCLES;
  localparam int MAXP   = (MAX_AT > MAX_FS) ? MAX_AT : MAX_FS;
  localparam int CW     = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] AREF_LAST    = CW'(AREF_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] FILTER_LAST  = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    SETTLE,
    RUN,
    FAULT
  } state_t;

`ifdef PLL_SEQ_AUTO_RETRY_EN
  localparam state_t FAIL_STATE = RESET_PLL;
`else
  localparam state_t FAIL_STATE = FAULT;
`endif

  state_t        state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic [CW-1:0] filt_cnt, next_filt;
  logic          lock_s1, lock_s2;
  logic          bump_retry;
  logic          next_areset, next_core_reset, next_clk_ok, next_fault;

  // Two-flop synchronizer for the PLL lock, which is asynchronous to clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
    end else begin
      lock_s1 <= pll_locked;
      lock_s2 <= lock_s1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RESET_PLL;
      cnt         <= '0;
      filt_cnt    <= '0;
      pll_areset  <= 1'b1;
      core_reset  <= 1'b1;
      clk_ok      <= 1'b0;
      fault       <= 1'b0;
      retry_count <= 8'd0;
    end else begin
      state      <= next_state;
      cnt        <= next_cnt;
      filt_cnt   <= next_filt;
      pll_areset <= next_areset;
      core_reset <= next_core_reset;
      clk_ok     <= next_clk_ok;
      fault      <= next_fault;
      if (bump_retry && (retry_count != 8'hFF))
        retry_count <= retry_count + 8'd1;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt + 1'b1;
    next_filt  = filt_cnt;
    bump_retry = 1'b0;

    case (state)
      RESET_PLL: begin
        if (cnt == AREF_LAST) begin
          next_state = WAIT_LOCK;
          next_cnt   = '0;
          next_filt  = '0;
        end
      end
      WAIT_LOCK: begin
        next_filt = lock_s2 ? filt_cnt + 1'b1 : '0;
        // Acceptance is tested first so it beats a timeout on the same cycle
        if (lock_s2 && (filt_cnt == FILTER_LAST)) begin
          next_state = SETTLE;
          next_cnt   = '0;
          next_filt  = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          bump_retry = 1'b1;
          next_state = FAIL_STATE;
          next_cnt   = '0;
          next_filt  = '0;
        end
      end
      SETTLE: begin
        if (!lock_s2) begin
          bump_retry = 1'b1;
          next_state = FAIL_STATE;
          next_cnt   = '0;
          next_filt  = '0;
        end else if (cnt == SETTLE_LAST) begin
          next_state = RUN;
          next_cnt   = '0;
        end
      end
      RUN: begin
        next_cnt = cnt;
        if (!lock_s2) begin
          bump_retry = 1'b1;
          next_state = FAIL_STATE;
          next_cnt   = '0;
          next_filt  = '0;
        end
      end
      FAULT: begin
        next_cnt = cnt;
      end
      default: begin
        next_state = RESET_PLL;
        next_cnt   = '0;
        next_filt  = '0;
      end
    endcase

    // A restart request overrides every other event and is never counted as a retry
    if (restart) begin
      next_state = RESET_PLL;
      next_cnt   = '0;
      next_filt  = '0;
      bump_retry = 1'b0;
    end

    next_areset     = (next_state == RESET_PLL) || (next_state == FAULT);
    next_core_reset = (next_state != RUN);
    next_clk_ok     = (next_state == RUN);
`ifdef PLL_SEQ_AUTO_RETRY_EN
    next_fault      = 1'b0;
`else
    next_fault      = (next_state == FAULT);
`endif
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: phase/age model compared every cycle plus literal timing pins.
// Honours PLL_SEQ_AUTO_RETRY_EN the same way as the design.
`timescale 1ns/1ps
module tb_pll_lock_sequencer;

  localparam int AREF     = 4;
  localparam int TIMEOUT  = 100;
  localparam int FILTER   = 3;
  localparam int SETTLE_N = 8;

`ifdef PLL_SEQ_AUTO_RETRY_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam int PH_AREF   = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_SETTLE = 2;
  localparam int PH_RUN    = 3;
  localparam int PH_FAULT  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_areset, core_reset, clk_ok, fault;
  logic [7:0] retry_count;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  bit started = 1'b0;

  pll_lock_sequencer #(
    .AREF_CYCLES  (AREF),
    .LOCK_TIMEOUT (TIMEOUT),
    .LOCK_FILTER  (FILTER),
    .SETTLE_CYCLES(SETTLE_N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_areset (pll_areset),
    .core_reset (core_reset),
    .clk_ok     (clk_ok),
    .fault      (fault),
    .retry_count(retry_count)
  );

  always #10 clk = ~clk;

  // Cycle index: 0 is the cycle in which reset is released
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Behavioural model: which phase we are in, how long we have been there, and the lock run length
  int         m_phase, m_age, m_run;
  logic [7:0] m_retry;
  logic [1:0] m_lock_hist;
  int         nx_phase, nx_age, nx_run;
  bit         failed;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase     <= PH_AREF;
      m_age       <= 0;
      m_run       <= 0;
      m_retry     <= 8'd0;
      m_lock_hist <= 2'b00;
    end else begin
      nx_phase = m_phase;
      nx_age   = m_age + 1;
      nx_run   = m_run;
      failed   = 1'b0;
      if (restart) begin
        nx_phase = PH_AREF;
        nx_age   = 0;
        nx_run   = 0;
      end else begin
        case (m_phase)
          PH_AREF:
            if (m_age + 1 == AREF) begin
              nx_phase = PH_WAIT; nx_age = 0; nx_run = 0;
            end
          PH_WAIT: begin
            nx_run = m_lock_hist[1] ? m_run + 1 : 0;
            if (nx_run == FILTER) begin
              nx_phase = PH_SETTLE; nx_age = 0; nx_run = 0;
            end else if (m_age + 1 == TIMEOUT) begin
              failed = 1'b1;
            end
          end
          PH_SETTLE:
            if (!m_lock_hist[1]) failed = 1'b1;
            else if (m_age + 1 == SETTLE_N) begin
              nx_phase = PH_RUN; nx_age = 0;
            end
          PH_RUN:
            if (!m_lock_hist[1]) failed = 1'b1;
          default: ;
        endcase
      end
      if (failed) begin
        nx_phase = AUTO ? PH_AREF : PH_FAULT;
        nx_age   = 0;
        nx_run   = 0;
        if (m_retry != 8'd255) m_retry <= m_retry + 8'd1;
      end
      m_phase     <= nx_phase;
      m_age       <= nx_age;
      m_run       <= nx_run;
      m_lock_hist <= {m_lock_hist[0], pll_locked};
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (started && !reset) begin
      checkOutput("model_pll_areset", {7'd0, pll_areset},
                  {7'd0, (m_phase == PH_AREF) || (m_phase == PH_FAULT)});
      checkOutput("model_core_reset", {7'd0, core_reset}, {7'd0, m_phase != PH_RUN});
      checkOutput("model_clk_ok", {7'd0, clk_ok}, {7'd0, m_phase == PH_RUN});
      checkOutput("model_fault", {7'd0, fault}, {7'd0, m_phase == PH_FAULT});
      checkOutput("model_retry", retry_count, m_retry);
    end
  end

  task automatic applyStimulus(input logic locked, input logic rst_req);
    pll_locked = locked;
    restart    = rst_req;
  endtask

  task automatic wait_until_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_pll_areset"}, {7'd0, pll_areset}, 8'd1);
    checkOutput({tag, "_core_reset"}, {7'd0, core_reset}, 8'd1);
    checkOutput({tag, "_clk_ok"}, {7'd0, clk_ok}, 8'd0);
    checkOutput({tag, "_fault"}, {7'd0, fault}, 8'd0);
    checkOutput({tag, "_retry"}, retry_count, 8'd0);
  endtask

  task automatic do_reset();
    applyStimulus(1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("reset");
    @(posedge clk);
    #1;
    reset   = 1'b0;
    started = 1'b1;
  endtask

  initial begin
    #100_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int e;
    #1;
    $display("[TB] pll_lock_sequencer bench, auto retry = %0d", AUTO);

    // Nominal lock
    do_reset();
    wait_until_cycle(3);
    checkOutput("nom_areset_c3", {7'd0, pll_areset}, 8'd1);
    wait_until_cycle(4);
    applyStimulus(1'b1, 1'b0);
    checkOutput("nom_areset_c4", {7'd0, pll_areset}, 8'd0);
    wait_until_cycle(16);
    checkOutput("nom_core_reset_c16", {7'd0, core_reset}, 8'd1);
    wait_until_cycle(17);
    checkOutput("nom_core_reset_c17", {7'd0, core_reset}, 8'd0);
    checkOutput("nom_clk_ok_c17", {7'd0, clk_ok}, 8'd1);
    checkOutput("nom_retry_c17", retry_count, 8'd0);

    // Lock loss in RUN
    wait_until_cycle(30);
    applyStimulus(1'b0, 1'b0);
    wait_until_cycle(32);
    checkOutput("loss_clk_ok_c32", {7'd0, clk_ok}, 8'd1);
    wait_until_cycle(33);
    applyStimulus(1'b1, 1'b0);
    checkOutput("loss_core_reset_c33", {7'd0, core_reset}, 8'd1);
    checkOutput("loss_clk_ok_c33", {7'd0, clk_ok}, 8'd0);
    checkOutput("loss_areset_c33", {7'd0, pll_areset}, 8'd1);
    checkOutput("loss_retry_c33", retry_count, 8'd1);
    wait_until_cycle(48);
    checkOutput("loss_relock_clk_ok_c48", {7'd0, clk_ok}, AUTO ? 8'd1 : 8'd0);
    checkOutput("loss_fault_c48", {7'd0, fault}, AUTO ? 8'd0 : 8'd1);

    // Filter glitch: synced high 6..7, low 8, high from 9 -> SETTLE at 12, RUN at 20
    do_reset();
    wait_until_cycle(4);
    applyStimulus(1'b1, 1'b0);
    wait_until_cycle(6);
    applyStimulus(1'b0, 1'b0);
    wait_until_cycle(7);
    applyStimulus(1'b1, 1'b0);
    wait_until_cycle(17);
    checkOutput("glitch_core_reset_c17", {7'd0, core_reset}, 8'd1);
    wait_until_cycle(19);
    checkOutput("glitch_core_reset_c19", {7'd0, core_reset}, 8'd1);
    wait_until_cycle(20);
    checkOutput("glitch_core_reset_c20", {7'd0, core_reset}, 8'd0);

    // Timeout with lock held low
    do_reset();
    wait_until_cycle(103);
    checkOutput("to_areset_c103", {7'd0, pll_areset}, 8'd0);
    wait_until_cycle(104);
    checkOutput("to_areset_c104", {7'd0, pll_areset}, 8'd1);
    checkOutput("to_retry_c104", retry_count, 8'd1);
    checkOutput("to_fault_c104", {7'd0, fault}, AUTO ? 8'd0 : 8'd1);

    // Restart coinciding with synchronized lock loss in RUN
    do_reset();
    wait_until_cycle(4);
    applyStimulus(1'b1, 1'b0);
    wait_until_cycle(30);
    applyStimulus(1'b0, 1'b0);
    wait_until_cycle(32);
    checkOutput("rs_clk_ok_c32", {7'd0, clk_ok}, 8'd1);
    applyStimulus(1'b0, 1'b1);
    wait_until_cycle(33);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rs_areset_c33", {7'd0, pll_areset}, 8'd1);
    checkOutput("rs_retry_c33", retry_count, 8'd0);
    checkOutput("rs_fault_c33", {7'd0, fault}, 8'd0);

    // Saturation: 260 timeouts, using restart to leave FAULT when auto retry is off
    do_reset();
    e = 0;
    for (int i = 0; i < 260; i++) begin
      wait_until_cycle(e + 104);
      if (i == 253) checkOutput("sat_retry_254", retry_count, 8'd254);
      if (i == 254) checkOutput("sat_retry_255", retry_count, 8'd255);
      if (AUTO) begin
        e = e + 104;
      end else begin
        applyStimulus(1'b0, 1'b1);
        wait_until_cycle(e + 105);
        applyStimulus(1'b0, 1'b0);
        e = e + 105;
      end
    end
    checkOutput("sat_retry_final", retry_count, 8'd255);

    // Asynchronous reset in the middle of SETTLE
    applyStimulus(1'b1, 1'b0);
    wait_until_cycle(e + 10);
    checkOutput("mid_settle_areset", {7'd0, pll_areset}, 8'd0);
    checkOutput("mid_settle_core_reset", {7'd0, core_reset}, 8'd1);
    checkOutput("mid_settle_retry", retry_count, 8'd255);
    #3;
    reset = 1'b1;
    #2;
    check_reset_values("async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
